traffic_monitor: RTL and testbench
==================================

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the completed-cycle counter.
REQ-002 Parameter MAX_HOLD, default 1: maximum consecutive samples of one phase (1 = phase must change every clock).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 red  input  1  observed red lamp from the traffic light controller.
REQ-006 amber  input  1  observed amber lamp.
REQ-007 green  input  1  observed green lamp.
REQ-008 clr  input  1  synchronous clear of err, err_code and cycle_count.
REQ-009 locked  output  1  monitor is synchronised to a legal sequence.
REQ-010 phase  output  2  last legal phase sampled: 0=R, 1=RA, 2=G, 3=A.
REQ-011 err  output  1  sticky error flag.
REQ-012 err_code  output  2  first-error cause: 0 none, 1 illegal pattern, 2 illegal transition, 3 hold exceeded.
REQ-013 cycle_count  output  CNT_WIDTH  completed full light cycles while locked.

Function
REQ-014 Inputs {red,amber,green} SHALL be sampled every rising clk edge; all outputs SHALL be registered and reflect that sample from the same edge onward (latency 1 clock).
REQ-015 Legal patterns: 100=R, 110=RA, 001=G, 010=A; the other four patterns (000, 011, 101, 111) SHALL be illegal.
REQ-016 Legal transitions: R->RA, RA->G, G->A, A->R; a repeat of the current phase SHALL be a hold.
REQ-017 FSM states UNLOCKED and LOCKED; reset state UNLOCKED.
REQ-018 UNLOCKED: first legal pattern SHALL set locked=1, phase to that pattern, hold counter to 1, without counting a cycle; illegal patterns SHALL keep UNLOCKED and SHALL NOT flag an error.
REQ-019 LOCKED: illegal pattern -> error code 1; legal non-successor, non-repeat pattern -> code 2; repeat when hold counter equals MAX_HOLD -> code 3.
REQ-020 Any error SHALL return the FSM to UNLOCKED (locked=0) on the same edge; phase SHALL keep its last legal value.
REQ-021 Legal transition SHALL reset hold counter to 1; legal repeat below MAX_HOLD SHALL increment it.
REQ-022 A->R transition while LOCKED SHALL increment cycle_count by 1, wrapping from all-ones to 0.
REQ-023 err SHALL be sticky; err_code SHALL capture only the first error since reset/clear and not be overwritten by later errors.
REQ-024 clr SHALL zero err, err_code and cycle_count; it SHALL NOT affect locked, phase or hold counter.
REQ-025 clr coincident with an error SHALL yield err=1 with the new code; clr coincident with A->R SHALL yield cycle_count=1.
REQ-026 Error priority when several apply: code 1 > code 2 > code 3.

Reset
REQ-027 rst=1 SHALL immediately force locked=0, phase=0, err=0, err_code=0, cycle_count=0, hold counter=0, FSM=UNLOCKED, independent of clk.
REQ-028 Reset asserted mid-sequence SHALL discard all progress; after release the monitor SHALL resynchronise per REQ-018.

Structure
REQ-029 Phase encodings, legal input patterns and error codes SHALL live in shared package traffic_pkg, also used by the light controller.
REQ-030 Pattern-to-phase decoding SHALL be one combinational sub-module traffic_decode (outputs phase, legal).

Verification
REQ-031 Reset, then drive R,RA,G,A repeating for 3 cycles (MAX_HOLD=1) -> locked=1 after first sample, err=0, cycle_count=2 (third A->R not reached until R after A).
REQ-032 While locked in G, drive 101 -> next edge err=1, err_code=1, locked=0; then R -> locked=1, err_code stays 1.
REQ-033 Locked in R, drive G -> err_code=2, locked=0; assert clr 1 clock -> err=0, err_code=0, cycle_count=0.
REQ-034 MAX_HOLD=1, hold RA for 2 samples -> err_code=3 on second; MAX_HOLD=3, hold RA 3 samples -> no error, 4th sample -> err_code=3.
REQ-035 CNT_WIDTH=2, run 5 full cycles -> cycle_count sequence 1,2,3,0,1.
REQ-036 Assert rst asynchronously between edges mid-cycle -> all outputs 0 before next edge; release, drive A,R -> locked=1, cycle_count=0 after the first A, 1 after R.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its monitor.
// Phase encodings, legal lamp patterns ({red,amber,green}), monitor error
// codes and monitor FSM states.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_RA = 2'd1,
        PH_G  = 2'd2,
        PH_A  = 2'd3
    } phase_e;

    // Lamp patterns as {red, amber, green}
    localparam logic [2:0] PAT_R  = 3'b100;
    localparam logic [2:0] PAT_RA = 3'b110;
    localparam logic [2:0] PAT_G  = 3'b001;
    localparam logic [2:0] PAT_A  = 3'b010;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_PATTERN    = 2'd1,
        ERR_TRANSITION = 2'd2,
        ERR_HOLD       = 2'd3
    } err_code_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } mon_state_e;

    // The phase order R -> RA -> G -> A -> R matches the encoding order,
    // so the legal successor is simply the next code modulo 4.
    function automatic phase_e next_phase(phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/traffic_monitor_if.sv
// Bus between a traffic light observer (master) and traffic_monitor (slave).
//   red/amber/green : observed lamps, sampled every rising clock edge
//   clr             : synchronous clear of err, err_code, cycle_count
//   locked, phase, err, err_code, cycle_count : registered monitor results
//   dbg_state       : monitor FSM state, exposed for checkers
// The lamps carry no handshake: every clock edge is one sample, there is no
// valid/ready pair and the monitor never back-pressures.
interface traffic_monitor_if
    import traffic_pkg::*;
#(
    parameter int CNT_WIDTH = 8
);
    logic                 red;
    logic                 amber;
    logic                 green;
    logic                 clr;
    logic                 locked;
    phase_e               phase;
    logic                 err;
    err_code_e            err_code;
    logic [CNT_WIDTH-1:0] cycle_count;
    mon_state_e           dbg_state;

    modport master (
        output red, amber, green, clr,
        input  locked, phase, err, err_code, cycle_count, dbg_state
    );

    modport slave (
        input  red, amber, green, clr,
        output locked, phase, err, err_code, cycle_count, dbg_state
    );
endinterface

// File: rtl/traffic_decode.sv
// Combinational pattern-to-phase decoder.
//   pattern_i : lamps as {red, amber, green}
//   phase_o   : decoded phase (PH_R when the pattern is illegal)
//   legal_o   : 1 when pattern_i is one of the four legal patterns
module traffic_decode
    import traffic_pkg::*;
(
    input  logic [2:0] pattern_i,
    output phase_e     phase_o,
    output logic       legal_o
);
    always_comb begin
        phase_o = PH_R;
        legal_o = 1'b1;
        case (pattern_i)
            PAT_R:   phase_o = PH_R;
            PAT_RA:  phase_o = PH_RA;
            PAT_G:   phase_o = PH_G;
            PAT_A:   phase_o = PH_A;
            default: legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/traffic_monitor.sv
// Traffic light sequence monitor.
//   clk : system clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : traffic_monitor_if slave modport (lamps + clr in, results out)
// Synchronises to the first legal lamp pattern, then checks every sample
// for illegal patterns, illegal transitions and over-long holds. Counts
// completed light cycles (A -> R) while locked. err/err_code are sticky
// and keep the first error until clr.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int MAX_HOLD  = 1
) (
    input logic              clk,
    input logic              rst,
    traffic_monitor_if.slave bus
);
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    mon_state_e           state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 err_q, err_d;
    err_code_e            code_q, code_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    phase_e    dec_phase;
    logic      dec_legal;
    err_code_e new_code;
    logic      wrap;

    traffic_decode u_decode (
        .pattern_i ({bus.red, bus.amber, bus.green}),
        .phase_o   (dec_phase),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
            phase_q <= PH_R;
            hold_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        err_d    = err_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        new_code = ERR_NONE;
        wrap     = 1'b0;

        // The if/else chain encodes the error priority: pattern > transition > hold.
        unique case (state_q)
            ST_UNLOCKED: begin
                if (dec_legal) begin
                    state_d = ST_LOCKED;
                    phase_d = dec_phase;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!dec_legal) begin
                    new_code = ERR_PATTERN;
                end else if (dec_phase == phase_q) begin
                    if (hold_q == HOLD_MAX) new_code = ERR_HOLD;
                    else                    hold_d   = hold_q + HOLD_W'(1);
                end else if (dec_phase == next_phase(phase_q)) begin
                    phase_d = dec_phase;
                    hold_d  = HOLD_W'(1);
                    wrap    = (phase_q == PH_A);
                end else begin
                    new_code = ERR_TRANSITION;
                end
            end
        endcase

        // Phase keeps its last legal value on error; only the lock drops.
        if (new_code != ERR_NONE) state_d = ST_UNLOCKED;

        // A clear still lets the current sample's events register.
        if (bus.clr) begin
            err_d  = (new_code != ERR_NONE);
            code_d = new_code;
            cnt_d  = CNT_WIDTH'(wrap);
        end else begin
            if (new_code != ERR_NONE && !err_q) begin
                err_d  = 1'b1;
                code_d = new_code;
            end
            if (wrap) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.phase       = phase_q;
    assign bus.err         = err_q;
    assign bus.err_code    = code_q;
    assign bus.cycle_count = cnt_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor. Two instances share one lamp stimulus:
// instance a (CNT_WIDTH=8, MAX_HOLD=1) and instance b (CNT_WIDTH=2,
// MAX_HOLD=3). A behavioural model predicts both each clock; directed
// sequences with literal expectations pin the model, then random lamps run.
module tb_traffic_monitor;
    logic clk;
    logic rst;
    logic chk_en;
    int   pass_cnt;
    int   total_cnt;

    traffic_monitor_if #(.CNT_WIDTH(8)) ifa ();
    traffic_monitor_if #(.CNT_WIDTH(2)) ifb ();

    traffic_monitor #(.CNT_WIDTH(8), .MAX_HOLD(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    traffic_monitor #(.CNT_WIDTH(2), .MAX_HOLD(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phase of each pattern {r,a,g}; -1 marks an illegal pattern.
    int pat_phase[8] = '{-1, 2, 3, -1, 0, -1, 1, -1};
    logic [2:0] phase_pat[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int max_hold[2] = '{1, 3};
    int cnt_mod[2]  = '{256, 4};

    int m_locked[2];
    int m_phase[2];
    int m_hold[2];
    int m_err[2];
    int m_code[2];
    int m_cnt[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_locked[i] = 0; m_phase[i] = 0; m_hold[i] = 0;
            m_err[i] = 0; m_code[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic [2:0] pat, logic c);
        int p;
        int code;
        int done_cycle;
        p = pat_phase[pat];
        code = 0;
        done_cycle = 0;
        if (m_locked[i] == 0) begin
            if (p >= 0) begin
                m_locked[i] = 1; m_phase[i] = p; m_hold[i] = 1;
            end
        end else if (p < 0) begin
            code = 1;
        end else if (p == m_phase[i]) begin
            if (m_hold[i] >= max_hold[i]) code = 3;
            else m_hold[i] = m_hold[i] + 1;
        end else if (p == (m_phase[i] + 1) % 4) begin
            done_cycle = (m_phase[i] == 3) ? 1 : 0;
            m_phase[i] = p;
            m_hold[i] = 1;
        end else begin
            code = 2;
        end
        if (code != 0) m_locked[i] = 0;
        if (c) begin
            m_err[i] = (code != 0) ? 1 : 0;
            m_code[i] = code;
            m_cnt[i] = done_cycle;
        end else begin
            if (code != 0 && m_err[i] == 0) begin
                m_err[i] = 1;
                m_code[i] = code;
            end
            m_cnt[i] = (m_cnt[i] + done_cycle) % cnt_mod[i];
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0, {ifa.red, ifa.amber, ifa.green}, ifa.clr);
            model_step(1, {ifb.red, ifb.amber, ifb.green}, ifb.clr);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.locked", int'(ifa.locked), m_locked[0]);
            check("a.phase", int'(ifa.phase), m_phase[0]);
            check("a.err", int'(ifa.err), m_err[0]);
            check("a.err_code", int'(ifa.err_code), m_code[0]);
            check("a.cycle_count", int'(ifa.cycle_count), m_cnt[0]);
            check("b.locked", int'(ifb.locked), m_locked[1]);
            check("b.phase", int'(ifb.phase), m_phase[1]);
            check("b.err", int'(ifb.err), m_err[1]);
            check("b.err_code", int'(ifb.err_code), m_code[1]);
            check("b.cycle_count", int'(ifb.cycle_count), m_cnt[1]);
        end
    end

    // ---------------- driver ----------------
    task automatic set_in(logic [2:0] pat, logic c);
        ifa.red = pat[2]; ifa.amber = pat[1]; ifa.green = pat[0]; ifa.clr = c;
        ifb.red = pat[2]; ifb.amber = pat[1]; ifb.green = pat[0]; ifb.clr = c;
    endtask

    task automatic step(logic [2:0] pat, logic c);
        set_in(pat, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, " a.locked"}, int'(ifa.locked), 0);
        check({tag, " a.phase"}, int'(ifa.phase), 0);
        check({tag, " a.err"}, int'(ifa.err), 0);
        check({tag, " a.err_code"}, int'(ifa.err_code), 0);
        check({tag, " a.cycle_count"}, int'(ifa.cycle_count), 0);
        check({tag, " b.locked"}, int'(ifb.locked), 0);
        check({tag, " b.cycle_count"}, int'(ifb.cycle_count), 0);
    endtask

    localparam logic [2:0] R = 3'b100, RA = 3'b110, G = 3'b001, A = 3'b010;
    int exp_b_cnt[5] = '{1, 2, 3, 0, 1};

    initial begin
        int cur;
        int r;
        logic [2:0] pat;
        logic c;

        pass_cnt = 0;
        total_cnt = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        set_in(3'b000, 1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        chk_en = 1'b1;
        rst = 1'b0;

        // Three full R,RA,G,A rounds: two A->R wraps seen.
        for (int k = 0; k < 3; k++) begin
            step(R, 0); step(RA, 0); step(G, 0); step(A, 0);
            if (k == 0) check("first lock a", int'(ifa.locked), 1);
        end
        check("3cyc a.cnt", int'(ifa.cycle_count), 2);
        check("3cyc b.cnt", int'(ifb.cycle_count), 2);
        check("3cyc a.err", int'(ifa.err), 0);
        check("3cyc model cnt", m_cnt[0], 2);

        // Illegal pattern while in G.
        step(R, 0); step(RA, 0); step(G, 0);
        step(3'b101, 0);
        check("illegal a.code", int'(ifa.err_code), 1);
        check("illegal a.locked", int'(ifa.locked), 0);
        check("illegal model code", m_code[1], 1);
        step(R, 0);
        check("relock a.locked", int'(ifa.locked), 1);
        check("relock a.code", int'(ifa.err_code), 1);

        // Clear coincident with a legal move, then a bad transition R->G.
        step(RA, 1);
        check("clr a.err", int'(ifa.err), 0);
        check("clr a.cnt", int'(ifa.cycle_count), 0);
        step(G, 0); step(A, 0); step(R, 0);
        check("wrap a.cnt", int'(ifa.cycle_count), 1);
        step(G, 0);
        check("trans a.code", int'(ifa.err_code), 2);
        check("trans b.code", int'(ifb.err_code), 2);
        check("trans a.locked", int'(ifa.locked), 0);
        step(3'b000, 1);
        check("clr2 a.err", int'(ifa.err), 0);
        check("clr2 a.code", int'(ifa.err_code), 0);
        check("clr2 a.cnt", int'(ifa.cycle_count), 0);

        // Holds: a (MAX_HOLD=1) fails on the 2nd RA, b (MAX_HOLD=3) on the 4th.
        step(R, 0); step(RA, 0); step(RA, 0);
        check("hold a.code", int'(ifa.err_code), 3);
        check("hold2 b.err", int'(ifb.err), 0);
        step(RA, 0);
        check("hold3 b.err", int'(ifb.err), 0);
        check("hold3 model b.err", m_err[1], 0);
        step(RA, 0);
        check("hold4 b.code", int'(ifb.err_code), 3);
        check("hold4 b.locked", int'(ifb.locked), 0);

        // Counter wrap on the 2-bit instance.
        step(A, 1);
        for (int k = 0; k < 5; k++) begin
            step(R, 0);
            check("wrap b.cnt", int'(ifb.cycle_count), exp_b_cnt[k]);
            check("wrap a.cnt", int'(ifa.cycle_count), k + 1);
            step(RA, 0); step(G, 0); step(A, 0);
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async");
        @(negedge clk);
        rst = 1'b0;
        step(A, 0);
        check("resync a.locked", int'(ifa.locked), 1);
        check("resync a.cnt", int'(ifa.cycle_count), 0);
        step(R, 0);
        check("resync a.cnt R", int'(ifa.cycle_count), 1);
        check("resync b.cnt R", int'(ifb.cycle_count), 1);

        // Random lamps, mostly following the legal sequence.
        cur = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      pat = phase_pat[(cur + 1) % 4];
            else if (r < 82) pat = phase_pat[cur];
            else             pat = 3'($urandom_range(0, 7));
            if (pat_phase[pat] >= 0) cur = pat_phase[pat];
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                step(pat, c);
                #2 rst = 1'b0;
            end else begin
                step(pat, c);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
